// File: rtl/pool2x2_sched.sv
// pool2x2_sched: sequencer for the 2x2/stride-2 max-pool line buffer; flags full windows with pooled coordinates.
// Optional POOL_STALL_CNT_EN adds a saturating count of HOLD cycles spent waiting on m_ready.
module pool2x2_sched #(
  parameter int WIDTH    = 8,
  parameter int HEIGHT   = 8,
  parameter int CHANNELS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          shift_en,
  output logic                          win_valid,
  input  logic                          m_ready,
  output logic [$clog2(HEIGHT/2):0]     win_row,
  output logic [$clog2(WIDTH/2):0]      win_col,
  output logic [$clog2(CHANNELS):0]     win_ch,
  output logic                          busy,
  output logic                          done
`ifdef POOL_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int RW  = $clog2(HEIGHT) + 1;
  localparam int HW  = $clog2(CHANNELS) + 1;
  localparam int WRW = $clog2(HEIGHT/2) + 1;
  localparam int WCW = $clog2(WIDTH/2) + 1;
  typedef enum logic [1:0] {IDLE, STREAM, HOLD, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [HW-1:0] ch;
  logic col_wrap, row_wrap, win_hit, last_px, fin;
  assign col_wrap  = col == CW'(WIDTH - 1);
  assign row_wrap  = row == RW'(HEIGHT - 1);
  // odd row/col closes a window; the trailing column/row of odd sizes never does
  assign win_hit   = row[0] & col[0] & (col < CW'(2*(WIDTH/2))) & (row < RW'(2*(HEIGHT/2)));
  assign last_px   = col_wrap & row_wrap & (ch == HW'(CHANNELS - 1));
  assign fin       = ch == HW'(CHANNELS);
  assign s_ready   = state == STREAM;
  assign shift_en  = s_valid & s_ready;
  assign win_valid = state == HOLD;
  assign busy      = (state == STREAM) | (state == HOLD);
  assign done      = state == DONE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? STREAM : IDLE;
      STREAM:  next = !shift_en ? STREAM : win_hit ? HOLD : last_px ? DONE : STREAM;
      HOLD:    next = !m_ready ? HOLD : fin ? DONE : STREAM;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      col     <= '0;
      row     <= '0;
      ch      <= '0;
      win_row <= '0;
      win_col <= '0;
      win_ch  <= '0;
    end else begin
      if (state == IDLE && start) begin
        col <= '0;
        row <= '0;
        ch  <= '0;
      end else if (shift_en) begin
        col <= col_wrap ? '0 : col + CW'(1);
        if (col_wrap) row <= row_wrap ? '0 : row + RW'(1);
        if (col_wrap && row_wrap) ch <= ch + HW'(1);
      end
      if (shift_en && win_hit) begin
        win_row <= WRW'(row >> 1);
        win_col <= WCW'(col >> 1);
        win_ch  <= ch;
      end
    end
`ifdef POOL_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cnt <= '0;
    else if (state == IDLE && start) stall_cnt <= '0;
    else if (state == HOLD && !m_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_pool2x2_sched.sv
// tb_pool2x2_sched: table-driven runs of a 4x4x2 sequencer with a window scoreboard, plus
// reset-in-HOLD and a 5x5x1 odd-size instance.
module tb_pool2x2_sched;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic start_a = 0, s_valid_a = 0, m_ready_a = 1;
  logic s_ready_a, shift_en_a, win_valid_a, busy_a, done_a;
  logic [1:0] win_row_a, win_col_a, win_ch_a;
  logic start_b = 0, s_valid_b = 0, m_ready_b = 1;
  logic s_ready_b, shift_en_b, win_valid_b, busy_b, done_b;
  logic [1:0] win_row_b, win_col_b;
  logic [0:0] win_ch_b;
`ifdef POOL_STALL_CNT_EN
  logic [15:0] stall_a, stall_b;
`endif
  pool2x2_sched #(.WIDTH(4), .HEIGHT(4), .CHANNELS(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
    .shift_en(shift_en_a), .win_valid(win_valid_a), .m_ready(m_ready_a), .win_row(win_row_a),
    .win_col(win_col_a), .win_ch(win_ch_a), .busy(busy_a), .done(done_a)
`ifdef POOL_STALL_CNT_EN
    , .stall_cnt(stall_a)
`endif
  );
  pool2x2_sched #(.WIDTH(5), .HEIGHT(5), .CHANNELS(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .shift_en(shift_en_b), .win_valid(win_valid_b), .m_ready(m_ready_b), .win_row(win_row_b),
    .win_col(win_col_b), .win_ch(win_ch_b), .busy(busy_b), .done(done_b)
`ifdef POOL_STALL_CNT_EN
    , .stall_cnt(stall_b)
`endif
  );
  typedef struct {int ch; int row; int col;} win_t;
  typedef struct {int vpct; int stall; bit hold_start; int exp_wins; int exp_shifts; int exp_stall;} vec_t;
  win_t q[$], qb[$];
  int tests = 0, fails = 0;
  int cyc = 0, shifts = 0, wins = 0, dones = 0, bad = 0, first_ws = -1, last_cons = 0, done_cyc = 0;
  int shifts_b = 0, wins_b = 0, dones_b = 0;
  bit mon_en = 0, monb_en = 0, prev_wv = 0;
  logic [5:0] snap = '0;
  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction
  always @(negedge clk) begin
    win_t e;
    cyc++;
    if (mon_en) begin
      if (shift_en_a) shifts++;
      if (shift_en_a && !s_valid_a) bad++;
      if (win_valid_a && !prev_wv) begin
        snap = {win_ch_a, win_row_a, win_col_a};
        if (first_ws < 0) first_ws = shifts;
      end
      if (win_valid_a && !m_ready_a) begin
        chk("stall_frozen", int'({s_ready_a, shift_en_a}), 0);
        chk("stall_coords", int'({win_ch_a, win_row_a, win_col_a}), int'(snap));
      end
      if (win_valid_a && m_ready_a) begin
        if (q.size() == 0) chk("win_extra", 1, 0);
        else begin
          e = q.pop_front();
          chk("win_ch", int'(win_ch_a), e.ch);
          chk("win_row", int'(win_row_a), e.row);
          chk("win_col", int'(win_col_a), e.col);
        end
        wins++;
        last_cons = cyc;
      end
      if (done_a) begin
        if (dones == 0) done_cyc = cyc;
        dones++;
      end
    end
    prev_wv = win_valid_a;
    if (monb_en) begin
      if (shift_en_b) shifts_b++;
      if (win_valid_b && m_ready_b) begin
        chk("b_col_range", int'(win_col_b < 2 && win_row_b < 2), 1);
        if (qb.size() == 0) chk("b_win_extra", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_win", int'({win_ch_b, win_row_b, win_col_b}), (e.ch << 4) | (e.row << 2) | e.col);
        end
        wins_b++;
      end
      if (done_b) dones_b++;
    end
  end
  task automatic run_a(input vec_t v, input int idx);
    int stall_left = v.stall;
    int guard = 0;
    int post = 0;
    q.delete();
    shifts = 0; wins = 0; dones = 0; bad = 0; first_ws = -1; last_cons = 0; done_cyc = 0;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 2; k++) q.push_back('{c, r, k});
    mon_en = 1;
    @(posedge clk); #1 start_a = 1;
    @(posedge clk); #1;
    while (post < 3 && guard < 2000) begin
      start_a   = v.hold_start && dones == 0;
      s_valid_a = $urandom_range(0, 99) < v.vpct;
      if (win_valid_a && wins == 0 && stall_left > 0) begin
        m_ready_a = 0;
        stall_left--;
      end else m_ready_a = 1;
      if (dones > 0) post++;
      guard++;
      @(posedge clk); #1;
    end
    s_valid_a = 0; start_a = 0; m_ready_a = 1;
    mon_en = 0;
    $display("[TB] run %0d: %0d windows, %0d shifts", idx, wins, shifts);
    chk("timeout", int'(guard < 2000), 1);
    chk("wins", wins, v.exp_wins);
    chk("shifts", shifts, v.exp_shifts);
    chk("dones", dones, 1);
    chk("shift_without_valid", bad, 0);
    chk("queue_left", q.size(), 0);
    chk("first_win_after_6th", first_ws, 6);
    chk("done_latency", done_cyc - last_cons, 1);
    chk("idle_after", int'({busy_a, s_ready_a, win_valid_a}), 0);
`ifdef POOL_STALL_CNT_EN
    chk("stall_cnt", int'(stall_a), v.exp_stall);
`endif
  endtask
  vec_t vecs[5];
  initial begin
    vecs[0] = '{100, 0, 0, 8, 32, 0};
    vecs[1] = '{100, 5, 0, 8, 32, 5};
    vecs[2] = '{50, 0, 0, 8, 32, 0};
    vecs[3] = '{100, 0, 1, 8, 32, 0};
    vecs[4] = '{50, 3, 1, 8, 32, 3};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'({s_ready_a, shift_en_a, win_valid_a, busy_a, done_a, win_row_a, win_col_a, win_ch_a}), 0);
    rst = 1;
    // drive into HOLD, then pull reset low for one clock
    @(posedge clk); #1 start_a = 1; s_valid_a = 1; m_ready_a = 0;
    @(posedge clk); #1 start_a = 0;
    for (int i = 0; i < 50 && !win_valid_a; i++) begin
      @(posedge clk); #1;
    end
    chk("hold_reached", int'(win_valid_a), 1);
    rst = 0;
    #1 chk("reset_in_hold", int'({s_ready_a, shift_en_a, win_valid_a, busy_a, done_a, win_row_a, win_col_a, win_ch_a}), 0);
    @(posedge clk); #1 rst = 1; s_valid_a = 0; m_ready_a = 1;
    @(posedge clk); #1 chk("idle_after_reset", int'(busy_a), 0);
    for (int i = 0; i < 5; i++) run_a(vecs[i], i);
    // odd-size frame: trailing row/column never windowed
    qb.push_back('{0, 0, 0}); qb.push_back('{0, 0, 1});
    qb.push_back('{0, 1, 0}); qb.push_back('{0, 1, 1});
    monb_en = 1;
    @(posedge clk); #1 start_b = 1; s_valid_b = 1; m_ready_b = 1;
    @(posedge clk); #1 start_b = 0;
    for (int i = 0; i < 500 && dones_b == 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1 s_valid_b = 0;
    monb_en = 0;
    chk("b_shifts", shifts_b, 25);
    chk("b_wins", wins_b, 4);
    chk("b_dones", dones_b, 1);
    chk("b_queue_left", qb.size(), 0);
    chk("b_idle", int'(busy_b), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
